// File: rtl/md_unit_param_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The master drives operands and the opcode; the slave returns status and HI/LO.
interface md_unit_param_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic [3:0]       MDop;
  logic             Flush;
  logic             start;
  logic             busy;
  logic             div0;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output D1, D2, MDop, Flush, input start, busy, div0, HI, LO);
  modport slave  (input D1, D2, MDop, Flush, output start, busy, div0, HI, LO);
endinterface

// File: rtl/md_unit_param.sv
// Multiply/divide unit owning HI/LO: fixed-latency multiply(-accumulate),
// iterative restoring divide with sign fix-up, and flush abort.
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic             Clk,
  input logic             Reset,
  md_unit_param_if.slave  bus
);

  localparam int CMAX  = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DFIX = 2'd3} state_t;

  state_t                 state_r, state_s;
  logic [WIDTH-1:0]       hi_r, hi_s, lo_r, lo_s;
  logic                   busy_r, busy_s, div0_r, div0_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [2*WIDTH-1:0]     acc_r, acc_s;
  logic [WIDTH-1:0]       quo_r, quo_s, rem_r, rem_s, dvs_r, dvs_s;
  logic                   neg_q_r, neg_q_s, neg_r_r, neg_r_s;
  logic [2*WIDTH-1:0]     ext1_s, ext2_s, prod_s, mul_res_s;
  logic [WIDTH:0]         rem_shift_s, diff_s;
  logic                   mul_signed_s, div_signed_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return WIDTH'(0) - v;
    end else begin
      return v;
    end
  endfunction

  assign bus.start = (bus.MDop >= 4'd3) && (bus.MDop <= 4'd10);
  assign bus.busy  = busy_r;
  assign bus.div0  = div0_r;
  assign bus.HI    = hi_r;
  assign bus.LO    = lo_r;

  // Product: sign- or zero-extend to 2*WIDTH so one unsigned multiply covers both.
  always_comb begin
    mul_signed_s = (bus.MDop == 4'd3) || (bus.MDop == 4'd7) || (bus.MDop == 4'd9);
    div_signed_s = (bus.MDop == 4'd5);
    ext1_s = mul_signed_s ? {{WIDTH{bus.D1[WIDTH-1]}}, bus.D1} : {{WIDTH{1'b0}}, bus.D1};
    ext2_s = mul_signed_s ? {{WIDTH{bus.D2[WIDTH-1]}}, bus.D2} : {{WIDTH{1'b0}}, bus.D2};
    prod_s = ext1_s * ext2_s;
    case (bus.MDop)
      4'd7, 4'd8:  mul_res_s = {hi_r, lo_r} + prod_s;
      4'd9, 4'd10: mul_res_s = {hi_r, lo_r} - prod_s;
      default:     mul_res_s = prod_s;
    endcase
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
  end

  // Next-state and datapath updates for the IDLE/MUL/DIV/DFIX sequencer.
  always_comb begin
    state_s = state_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    busy_s  = busy_r;
    div0_s  = 1'b0;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    quo_s   = quo_r;
    rem_s   = rem_r;
    dvs_s   = dvs_r;
    neg_q_s = neg_q_r;
    neg_r_s = neg_r_r;
    if (bus.Flush) begin
      state_s = IDLE;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          case (bus.MDop)
            4'd1: hi_s = bus.D1;
            4'd2: lo_s = bus.D1;
            4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10: begin
              acc_s   = mul_res_s;
              cnt_s   = CNT_W'(MUL_LAT - 1);
              busy_s  = 1'b1;
              state_s = MUL;
            end
            4'd5, 4'd6: begin
              if (bus.D2 == '0) begin
                div0_s = 1'b1;
              end else begin
                quo_s   = mag(bus.D1, div_signed_s);
                dvs_s   = mag(bus.D2, div_signed_s);
                rem_s   = '0;
                neg_q_s = div_signed_s & (bus.D1[WIDTH-1] ^ bus.D2[WIDTH-1]);
                neg_r_s = div_signed_s & bus.D1[WIDTH-1];
                cnt_s   = CNT_W'(WIDTH - 1);
                busy_s  = 1'b1;
                state_s = DIV;
              end
            end
            default: state_s = IDLE;
          endcase
        end
        MUL: begin
          if (cnt_r == '0) begin
            {hi_s, lo_s} = acc_r;
            busy_s       = 1'b0;
            state_s      = IDLE;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        DIV: begin
          // Restore on borrow: keep the shifted remainder and shift in a zero.
          if (diff_s[WIDTH]) begin
            rem_s = rem_shift_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b0};
          end else begin
            rem_s = diff_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b1};
          end
          if (cnt_r == '0) begin
            state_s = DFIX;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        DFIX: begin
          lo_s    = neg_q_r ? (WIDTH'(0) - quo_r) : quo_r;
          hi_s    = neg_r_r ? (WIDTH'(0) - rem_r) : rem_r;
          busy_s  = 1'b0;
          state_s = IDLE;
        end
        default: begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      hi_r    <= '0;
      lo_r    <= '0;
      busy_r  <= 1'b0;
      div0_r  <= 1'b0;
      cnt_r   <= '0;
      acc_r   <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      state_r <= state_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= busy_s;
      div0_r  <= div0_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      quo_r   <= quo_s;
      rem_r   <= rem_s;
      dvs_r   <= dvs_s;
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Randomised bench for md_unit_param: a longint arithmetic model of HI/LO
// predicts results and busy lengths for every operation issued.
module tb_md_unit_param;
  localparam int W = 32;
  localparam int LAT = 5;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  md_unit_param_if #(.WIDTH(W)) bus ();
  md_unit_param #(.WIDTH(W), .MUL_LAT(LAT)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  function automatic void model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub, p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {hi_m, lo_m};
    case (op)
      4'd1: hi_m = a;
      4'd2: lo_m = a;
      4'd3, 4'd7, 4'd9: p = longint'(sa * sb);
      4'd4, 4'd8, 4'd10: p = ua * ub;
      default: p = 64'd0;
    endcase
    if (op == 4'd3 || op == 4'd4) {hi_m, lo_m} = p;
    else if (op == 4'd7 || op == 4'd8) {hi_m, lo_m} = acc + p;
    else if (op == 4'd9 || op == 4'd10) {hi_m, lo_m} = acc - p;
    else if (op == 4'd5 && b != 0) begin
      lo_m = W'(sa / sb);
      hi_m = W'(sa % sb);
    end else if (op == 4'd6 && b != 0) begin
      lo_m = W'(ua / ub);
      hi_m = W'(ua % ub);
    end
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
    if ((op >= 4'd3 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10)) return LAT;
    if ((op == 4'd5 || op == 4'd6) && b != 0) return W + 1;
    return 0;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
    bus.MDop = op; bus.D1 = a; bus.D2 = b;
    @(negedge Clk);
    bus.MDop = 4'd0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge Clk);
    end
  endtask

  task automatic do_check(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int cyc;
    run_op(op, a, b, cyc);
    model_op(op, a, b);
    checks++;
    if (cyc !== exp_lat(op, b)) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, cyc, exp_lat(op, b)); end
    checks++;
    if (bus.HI !== hi_m || bus.LO !== lo_m) begin
      errors++; $display("FAIL %s op=%0d a=%h b=%h HI/LO got=%h/%h exp=%h/%h", name, op, a, b, bus.HI, bus.LO, hi_m, lo_m);
    end
  endtask

  task automatic test_reset;
    bus.MDop = 4'd0; bus.D1 = '0; bus.D2 = '0; bus.Flush = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0 || bus.div0 !== 1'b0) begin
      errors++; $display("FAIL reset_state HI=%h LO=%h busy=%b div0=%b exp all 0", bus.HI, bus.LO, bus.busy, bus.div0);
    end
    Reset = 1'b1;
    do_check(4'd1, 32'h0BAD_F00D, 32'd0, "pre_reset_mthi");
    bus.MDop = 4'd5; bus.D1 = 32'd100; bus.D2 = 32'd3;
    @(negedge Clk);
    bus.MDop = 4'd0;
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_div HI=%h LO=%h busy=%b exp 0/0/0", bus.HI, bus.LO, bus.busy);
    end
    hi_m = '0; lo_m = '0;
    @(negedge Clk);
    Reset = 1'b1;
    do_check(4'd2, 32'h0000_1234, 32'd0, "mtlo_after_reset");
  endtask

  task automatic test_start;
    bus.Flush = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.MDop = 4'(i);
      bus.D1 = $urandom; bus.D2 = $urandom;
      #1;
      checks++;
      if (bus.start !== (i >= 3 && i <= 10)) begin
        errors++; $display("FAIL start_decode MDop=%0d got=%b exp=%b", i, bus.start, (i >= 3 && i <= 10));
      end
    end
    bus.MDop = 4'd0;
    @(negedge Clk);
    bus.Flush = 1'b0;
    checks++;
    if (bus.HI !== hi_m || bus.LO !== lo_m || bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ops HI/LO got=%h/%h exp=%h/%h busy=%b", bus.HI, bus.LO, hi_m, lo_m, bus.busy);
    end
  endtask

  task automatic test_mthi_mtlo;
    for (int i = 0; i < 4; i++) begin
      do_check(4'd1, $urandom, 32'd0, "mthi_rand");
      do_check(4'd2, $urandom, 32'd0, "mtlo_rand");
    end
  endtask

  task automatic test_mult;
    logic [3:0] ops [6];
    ops = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
    do_check(4'd3, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    do_check(4'd4, 32'hFFFF_FFFE, 32'd3, "multu_neg2x3");
    do_check(4'd1, 32'd0, 32'd0, "mthi0");
    do_check(4'd2, 32'hFFFF_FFFF, 32'd0, "mtlo_ff");
    do_check(4'd7, 32'd1, 32'd1, "madd_carry");
    do_check(4'd10, 32'd2, 32'd1, "msubu_borrow");
    for (int i = 0; i < 12; i++) begin
      do_check(ops[$urandom_range(0, 5)], $urandom, $urandom, "mul_family_rand");
    end
  endtask

  task automatic test_div;
    do_check(4'd5, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    do_check(4'd6, 32'd100, 32'd7, "divu_100by7");
    do_check(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
    do_check(4'd6, 32'hFFFF_FFFF, 32'd1, "divu_max_by1");
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] d;
      d = (i % 2 == 0) ? W'($urandom_range(1, 300)) : ($urandom | 32'd1);
      if ($urandom_range(0, 1) == 1) d = W'(0) - d;
      do_check((i % 3 == 0) ? 4'd6 : 4'd5, $urandom, d, "div_rand");
    end
  endtask

  task automatic test_div0;
    do_check(4'd1, 32'd5, 32'd0, "mthi5");
    do_check(4'd2, 32'd6, 32'd0, "mtlo6");
    bus.MDop = 4'd5; bus.D1 = 32'd77; bus.D2 = 32'd0;
    @(negedge Clk);
    bus.MDop = 4'd0;
    checks++;
    if (bus.div0 !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL div0_pulse div0=%b busy=%b exp 1/0", bus.div0, bus.busy);
    end
    @(negedge Clk);
    checks++;
    if (bus.div0 !== 1'b0 || bus.busy !== 1'b0 || bus.HI !== 32'd5 || bus.LO !== 32'd6) begin
      errors++; $display("FAIL div0_after div0=%b busy=%b HI=%h LO=%h exp 0/0/5/6", bus.div0, bus.busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_flush;
    do_check(4'd1, 32'hAA, 32'd0, "mthi_aa");
    do_check(4'd2, 32'hAA, 32'd0, "mtlo_aa");
    bus.MDop = 4'd5; bus.D1 = 32'd1000; bus.D2 = 32'd9;
    @(negedge Clk);
    bus.MDop = 4'd0;
    repeat (2) @(negedge Clk);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'hAA || bus.LO !== 32'hAA) begin
      errors++; $display("FAIL flush_div busy=%b HI=%h LO=%h exp 0/aa/aa", bus.busy, bus.HI, bus.LO);
    end
    repeat (40) @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'hAA || bus.LO !== 32'hAA) begin
      errors++; $display("FAIL flush_div_later busy=%b HI=%h LO=%h exp 0/aa/aa", bus.busy, bus.HI, bus.LO);
    end
    bus.MDop = 4'd3; bus.D1 = 32'd7; bus.D2 = 32'd9;
    @(negedge Clk);
    bus.MDop = 4'd0;
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    repeat (LAT + 2) @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'hAA || bus.LO !== 32'hAA) begin
      errors++; $display("FAIL flush_mult busy=%b HI=%h LO=%h exp 0/aa/aa", bus.busy, bus.HI, bus.LO);
    end
    bus.Flush = 1'b1; bus.MDop = 4'd1; bus.D1 = 32'h55;
    @(negedge Clk);
    bus.Flush = 1'b0; bus.MDop = 4'd0;
    @(negedge Clk);
    checks++;
    if (bus.HI !== 32'hAA) begin
      errors++; $display("FAIL flush_mthi HI got=%h exp=aa", bus.HI);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    bus.MDop = 4'd4; bus.D1 = a; bus.D2 = b;
    @(negedge Clk);
    model_op(4'd4, a, b);
    bus.MDop = 4'd1; bus.D1 = 32'h777;
    repeat (LAT - 1) @(negedge Clk);
    bus.MDop = 4'd0;
    @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== hi_m || bus.LO !== lo_m) begin
      errors++; $display("FAIL ignore_while_busy busy=%b HI/LO got=%h/%h exp=%h/%h", bus.busy, bus.HI, bus.LO, hi_m, lo_m);
    end
    do_check(4'd1, 32'h1357_9BDF, 32'd0, "mthi_right_after");
    do_check(4'd9, $urandom, $urandom, "msub_right_after");
  endtask

  initial begin
    test_reset();
    test_start();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div0();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
Parametrised multiply/divide unit for the EX stage of the pipelined CPU. It holds the architectural HI/LO registers and executes mthi/mtlo, signed and unsigned mult/div, and the new multiply-accumulate ops madd/maddu/msub/msubu.
- Multiply has a configurable fixed latency.
- Divide is a genuine iterative restoring divider with divide-by-zero detection.
- A Flush input lets the exception logic abort an in-flight operation without corrupting HI/LO.

Parameters:
WIDTH, 32, operand and HI/LO width (>=8, even)
MUL_LAT, 5, cycles busy is high for mult/madd/msub family (>=1)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
D1  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
D2  input  WIDTH  rt operand (divisor / multiplier)
MDop  input  4  0 none, 1 mthi, 2 mtlo, 3 mult, 4 multu, 5 div, 6 divu, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none
Flush  input  1  abort in-flight op, discard issue this cycle
start  output  1  combinational: MDop in {3..10}
busy  output  1  registered: multi-cycle op in flight
div0  output  1  registered one-cycle pulse: div/divu issued with D2==0
HI  output  WIDTH  architectural HI
LO  output  WIDTH  architectural LO

Behaviour:
- Reset (Reset=0, asynchronous):
  - HI=LO=0, busy=0, div0=0.
  - FSM to IDLE, counters and datapath registers cleared.
  - Reset mid-operation discards the op.
- Decided: one clock; reset is asynchronous and active-low.
- FSM states:
  - IDLE: accepts MDop.
  - MUL: counting MUL_LAT.
  - DIV: WIDTH iterations.
  - DFIX: sign correction.
- Issue rules:
  - Issue is accepted only in IDLE with Flush=0.
  - MDop is ignored while busy=1; the hazard unit stalls using start and busy.
- mthi/mtlo: HI (or LO) <= D1 at the issuing edge. Visible next cycle, busy stays 0.
- mult/multu:
  - The full 2*WIDTH product is registered at issue.
  - busy=1 for exactly MUL_LAT cycles after the issue edge.
  - {HI,LO} are updated on the edge that drops busy.
- madd/maddu/msub/msubu:
  - Same timing as mult/multu.
  - Result is {HI,LO} ± product, mod 2^(2*WIDTH), using HI/LO as sampled at issue.
  - madd/msub use the signed product; maddu/msubu use the unsigned product.
- div/divu:
  - D2 != 0:
    - The DIV state runs WIDTH restoring iterations on magnitudes, one quotient bit per cycle.
    - DFIX then applies signs: quotient negated if operand signs differ; remainder takes the dividend's sign.
    - busy=1 for exactly WIDTH+1 cycles; LO=quotient, HI=remainder on the edge that drops busy.
  - D2 == 0: no state change, HI/LO unchanged, busy stays 0, div0=1 for one cycle after the issue edge.
  - Signed MIN / -1: LO=MIN, HI=0 (wrap), no flag.
  - divu treats operands as unsigned; no sign fix, DFIX still consumes one cycle for uniform latency.
- Flush=1 at a rising edge:
  - Any in-flight op is discarded; FSM to IDLE, busy=0, HI/LO keep their pre-op values.
  - An op presented the same cycle (including mthi/mtlo) is ignored.
  - Flush in IDLE with MDop=0 has no effect.
- Completion and a new issue never coincide: a new op is sampled only once busy is low.
- start is pure decode, independent of busy and Flush.

Test Plan:
- Reset: Reset=0 mid-div (cycle 10), then released -> HI=LO=0, busy=0 immediately; subsequent mtlo D1=0x1234 gives LO=0x1234 next cycle.
- mult D1=0xFFFFFFFE (-2), D2=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- madd with HI=0, LO=0xFFFFFFFF, D1=D2=1 -> after 5 cycles HI=1, LO=0. Then msubu D1=2, D2=1 -> HI=0, LO=0xFFFFFFFE.
- div D1=-7, D2=2 -> busy high 33 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 100/7 -> LO=14, HI=2. div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- div D2=0 with HI=5, LO=6 -> div0 pulses one cycle, busy never rises, HI=5, LO=6.
- Flush asserted at cycle 3 of a div (HI=LO=0xAA) -> busy falls next edge, HI/LO remain 0xAA. Flush with simultaneous mthi -> HI unchanged.
